// File: rtl/wb_result_stage.sv
// Registered writeback stage: selects the retiring result, extends load data and
// holds the pipeline while a load waits for memory.
module wb_result_stage #(
  parameter int W       = 32,
  parameter int NSRC    = 4,
  parameter int ALU_IDX = 0,
  parameter int MEM_IDX = 1,
  localparam int SELW   = ($clog2(NSRC) > 1) ? $clog2(NSRC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SELW-1:0]   in_sel,
  input  logic [NSRC*W-1:0] in_src,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [2:0]        in_funct3,
  input  logic              flush,
  input  logic              dmem_rvalid,
  input  logic [W-1:0]      dmem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [W-1:0]      rf_wdata,
  output logic              busy
);

  localparam int OFFW = $clog2(W / 8);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ready;
  logic            r_busy;
  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [W-1:0]    r_rf_wdata;
  logic [4:0]      r_pend_rd;
  logic            r_pend_we;
  logic [2:0]      r_pend_f3;
  logic [OFFW-1:0] r_pend_off;

  logic [W-1:0]    w_sel_data;
  logic [OFFW-1:0] w_off;
  logic            w_is_load;
  logic            w_capture;
  logic            w_wr_req;
  logic            w_wr_en;
  logic [4:0]      w_wr_rd;
  logic [W-1:0]    w_wr_data;
  logic            w_we_nxt;
  logic [4:0]      w_rd_nxt;
  logic [W-1:0]    w_wdata_nxt;

  // Sub-word load lanes are shifted down by the byte offset, then sign- or
  // zero-extended by shifting up to the MSB and back down.
  function automatic logic [W-1:0] f_load_extend(
    input logic [2:0]      f3,
    input logic [OFFW-1:0] off,
    input logic [W-1:0]    data
  );
    logic [W-1:0] lane;
    logic [W-1:0] top;
    int           size_bits;
    int           pad;
    lane          = data >> {off, 3'b000};
    size_bits     = 32'sd8 << f3[1:0];
    f_load_extend = data;
    if ((f3 == 3'b111) || (size_bits >= W)) begin
      f_load_extend = data;
    end else begin
      pad = W - size_bits;
      top = lane << pad;
      if (f3[2]) begin
        f_load_extend = top >> pad;
      end else begin
        f_load_extend = $signed(top) >>> pad;
      end
    end
  endfunction

  assign w_off     = in_src[ALU_IDX*W +: OFFW];
  assign w_is_load = (in_sel == SELW'(MEM_IDX));

  // AND-OR source mux; an out-of-range select matches no slot and yields zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_sel_data = w_sel_data | (in_src[k*W +: W] & {W{in_sel == SELW'(k)}});
    end
  end

  // Next-state, capture and write-port decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wr_req    = 1'b0;
    w_wr_en     = in_reg_write;
    w_wr_rd     = in_rd;
    w_wr_data   = w_sel_data;
    w_we_nxt    = 1'b0;
    w_rd_nxt    = r_rf_rd;
    w_wdata_nxt = r_rf_wdata;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_is_load) begin
            if (dmem_rvalid) begin
              w_wr_req  = 1'b1;
              w_wr_data = f_load_extend(in_funct3, w_off, dmem_rdata);
            end else begin
              w_capture   = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end else begin
            w_wr_req = 1'b1;
          end
        end else begin
          w_wr_req = 1'b0;
        end
      end
      ST_WAIT: begin
        w_wr_en   = r_pend_we;
        w_wr_rd   = r_pend_rd;
        w_wr_data = f_load_extend(r_pend_f3, r_pend_off, dmem_rdata);
        if (dmem_rvalid) begin
          w_wr_req    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Flush overrides everything on its edge, including a late rvalid.
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
      w_wr_req    = 1'b0;
    end else begin
      w_capture   = w_capture;
    end
    if (w_wr_req && w_wr_en && (w_wr_rd != 5'd0)) begin
      w_we_nxt    = 1'b1;
      w_rd_nxt    = w_wr_rd;
      w_wdata_nxt = w_wr_data;
    end else begin
      w_we_nxt    = 1'b0;
    end
  end

  // FSM state with registered handshake and busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt == ST_WAIT);
    end
  end

  // Register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we    <= w_we_nxt;
      r_rf_rd    <= w_rd_nxt;
      r_rf_wdata <= w_wdata_nxt;
    end
  end

  // Context of a load still waiting on memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_rd  <= 5'd0;
      r_pend_we  <= 1'b0;
      r_pend_f3  <= 3'b000;
      r_pend_off <= '0;
    end else if (w_capture) begin
      r_pend_rd  <= in_rd;
      r_pend_we  <= in_reg_write;
      r_pend_f3  <= in_funct3;
      r_pend_off <= w_off;
    end else begin
      r_pend_rd  <= r_pend_rd;
      r_pend_we  <= r_pend_we;
      r_pend_f3  <= r_pend_f3;
      r_pend_off <= r_pend_off;
    end
  end

  assign in_ready = r_ready;
  assign busy     = r_busy;
  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_wb_result_stage;
  localparam int W       = 32;
  localparam int NSRC    = 5;
  localparam int MEM_IDX = 1;
  localparam int SELW    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SELW-1:0]   in_sel = '0;
  logic [NSRC*W-1:0] in_src = '0;
  logic [4:0]        in_rd = 5'd0;
  logic              in_reg_write = 1'b0;
  logic [2:0]        in_funct3 = 3'b000;
  logic              flush = 1'b0;
  logic              dmem_rvalid = 1'b0;
  logic [W-1:0]      dmem_rdata = '0;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [W-1:0]      rf_wdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_pend = 1'b0;
  logic [4:0]  m_p_rd;
  bit          m_p_rw;
  logic [2:0]  m_p_f3;
  int          m_p_off;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_wdata = 32'd0;

  wb_result_stage #(.W(W), .NSRC(NSRC), .ALU_IDX(0), .MEM_IDX(MEM_IDX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_src(in_src), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_funct3(in_funct3), .flush(flush), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_slot(int k);
    return in_src[k*32 +: 32];
  endfunction

  task automatic set_slot(int k, logic [31:0] v);
    in_src[k*32 +: 32] = v;
  endtask

  function automatic logic [31:0] ref_load(logic [2:0] f3, int off, logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * off);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic model_step();
    bit          wr;
    bit          rw;
    logic [4:0]  rd;
    logic [31:0] res;
    wr = 1'b0; rw = 1'b0; rd = 5'd0; res = 32'd0;
    if (!m_pend) begin
      if (in_valid) begin
        if (in_sel == SELW'(MEM_IDX)) begin
          if (dmem_rvalid) begin
            wr = 1'b1; rd = in_rd; rw = in_reg_write;
            res = ref_load(in_funct3, int'(get_slot(0) & 32'd3), dmem_rdata);
          end else begin
            m_pend = 1'b1; m_p_rd = in_rd; m_p_rw = in_reg_write;
            m_p_f3 = in_funct3; m_p_off = int'(get_slot(0) & 32'd3);
          end
        end else begin
          wr = 1'b1; rd = in_rd; rw = in_reg_write;
          res = (int'(in_sel) < NSRC) ? get_slot(int'(in_sel)) : 32'd0;
        end
      end
    end else if (dmem_rvalid) begin
      wr = 1'b1; rd = m_p_rd; rw = m_p_rw;
      res = ref_load(m_p_f3, m_p_off, dmem_rdata);
      m_pend = 1'b0;
    end
    if (flush) begin
      wr = 1'b0;
      m_pend = 1'b0;
    end
    m_we = wr && rw && (rd != 5'd0);
    if (m_we) begin
      m_rd = rd;
      m_wdata = res;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; dmem_rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rf_we, rf_rd, rf_wdata, busy, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got we=%0b rd=%0d data=%h busy=%0b ready=%0b", rf_we, rf_rd, rf_wdata, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_write();
    set_slot(0, 32'h12345678);
    in_sel = 3'd0; in_rd = 5'd5; in_reg_write = 1'b1; in_valid = 1'b1;
    cycle();
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h12345678} ||
        {rf_we, rf_rd, rf_wdata} !== {m_we, m_rd, m_wdata}) begin
      errors++;
      $display("FAIL alu_write: got we=%0b rd=%0d data=%h want we=1 rd=5 data=12345678", rf_we, rf_rd, rf_wdata);
    end
    idle_inputs();
    cycle();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_write_pulse: got we=%0b want 0", rf_we);
    end
  endtask

  task automatic test_hit_loads();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    int          offs [4] = '{3, 3, 2, 0};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      set_slot(0, 32'h00001000 | 32'(offs[i]));
      in_sel = 3'(MEM_IDX); in_funct3 = f3s[i]; in_rd = 5'(10 + i); in_reg_write = 1'b1;
      in_valid = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF0000;
      cycle();
      checks++;
      if ({rf_we, rf_rd, rf_wdata, in_ready} !== {1'b1, 5'(10 + i), exps[i], 1'b1} ||
          rf_wdata !== m_wdata) begin
        errors++;
        $display("FAIL hit_load[%0d]: got we=%0b rd=%0d data=%h ready=%0b want data=%h", i, rf_we, rf_rd, rf_wdata, in_ready, exps[i]);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_delayed_load();
    set_slot(0, 32'h00002000);
    in_sel = 3'(MEM_IDX); in_funct3 = 3'b010; in_rd = 5'd7; in_reg_write = 1'b1;
    in_valid = 1'b1; dmem_rvalid = 1'b0;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, busy, rf_we} !== {1'b0, 1'b1, 1'b0} || in_ready !== !m_pend) begin
        errors++;
        $display("FAIL delayed_wait[%0d]: got ready=%0b busy=%0b we=%0b want 0 1 0", i, in_ready, busy, rf_we);
      end
      if (i == 2) begin
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
      end
      cycle();
    end
    checks++;
    if ({rf_we, rf_rd, rf_wdata, in_ready, busy} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0} ||
        rf_wdata !== m_wdata) begin
      errors++;
      $display("FAIL delayed_write: got we=%0b rd=%0d data=%h ready=%0b busy=%0b", rf_we, rf_rd, rf_wdata, in_ready, busy);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_flush_wait();
    in_sel = 3'(MEM_IDX); in_funct3 = 3'b010; in_rd = 5'd9; in_reg_write = 1'b1;
    in_valid = 1'b1; dmem_rvalid = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got busy=%0b want 1", busy);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if ({in_ready, busy, rf_we} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_ready: got ready=%0b busy=%0b we=%0b want 1 0 0", in_ready, busy, rf_we);
    end
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid = (i == 1); dmem_rdata = 32'hCAFEF00D;
      cycle();
      checks++;
      if (rf_we !== 1'b0 || rf_we !== m_we) begin
        errors++;
        $display("FAIL flush_nowrite[%0d]: got we=%0b want 0", i, rf_we);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sels [4] = '{3'd2, 3'd3, 3'd2, 3'd5};
    logic [4:0]  rds  [4] = '{5'd3, 5'd4, 5'd0, 5'd6};
    logic        wes  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0]  xrd  [4] = '{5'd3, 5'd4, 5'd4, 5'd6};
    logic [31:0] xdat [4] = '{32'h104, 32'h2000, 32'h2000, 32'h0};
    set_slot(2, 32'h104); set_slot(3, 32'h2000); set_slot(4, 32'h5555AAAA);
    in_reg_write = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = sels[i]; in_rd = rds[i];
      cycle();
      checks++;
      if ({rf_we, rf_rd, rf_wdata, in_ready} !== {wes[i], xrd[i], xdat[i], 1'b1} ||
          {rf_we, rf_rd, rf_wdata} !== {m_we, m_rd, m_wdata}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h", i, rf_we, rf_rd, rf_wdata, wes[i], xrd[i], xdat[i]);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NSRC; k++) begin
        set_slot(k, $urandom);
      end
      in_valid     = ($urandom_range(0, 9) < 7);
      in_sel       = ($urandom_range(0, 9) < 4) ? 3'(MEM_IDX) : 3'($urandom_range(0, 7));
      in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_reg_write = ($urandom_range(0, 7) != 0);
      in_funct3    = 3'($urandom_range(0, 7));
      dmem_rvalid  = $urandom_range(0, 1) == 1;
      dmem_rdata   = $urandom;
      flush        = ($urandom_range(0, 15) == 0);
      cycle();
      checks++;
      if ({rf_we, rf_rd, rf_wdata, busy, in_ready} !== {m_we, m_rd, m_wdata, m_pend, !m_pend}) begin
        errors++;
        $display("FAIL random[%0d]: got we=%0b rd=%0d data=%h busy=%0b ready=%0b want we=%0b rd=%0d data=%h busy=%0b", i, rf_we, rf_rd, rf_wdata, busy, in_ready, m_we, m_rd, m_wdata, m_pend);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_wait();
    set_slot(0, 32'h00003000);
    in_sel = 3'(MEM_IDX); in_funct3 = 3'b010; in_rd = 5'd12; in_reg_write = 1'b1;
    in_valid = 1'b1; dmem_rvalid = 1'b0;
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    m_pend = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0;
    checks++;
    if ({rf_we, rf_rd, rf_wdata, busy, in_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_wait: got we=%0b rd=%0d data=%h busy=%0b ready=%0b", rf_we, rf_rd, rf_wdata, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h13572468;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({rf_we, in_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stray_rvalid[%0d]: got we=%0b ready=%0b busy=%0b want 0 1 0", i, rf_we, in_ready, busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_hit_loads();
    test_delayed_load();
    test_flush_wait();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
